vpe_dequant_sched: RTL and testbench
====================================

Name: vpe_dequant_sched

Overview:
- Per-tile sequencer in front of the vpe_dequanter.
- Holds a per-column FP32 scale table and accepts a row-major PSUM stream (row 0 col 0..C-1, row 1, ...).
- Tags each element with its column's scale and the job's dequant-enable, then presents it to the dequanter through one register stage.
- Counts rows and columns, reports busy/done, and rejects configuration changes mid-tile.

Parameters:
- PSUM_WIDTH, 32, width of a PSUM element.
- NUM_COLS, 8, scale-table depth and maximum columns per tile.
- ROW_W, 16, width of the row-count configuration.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- cfg_start  in  1  pulse; starts a job (honoured only in IDLE).
- cfg_dequant_en  in  1  job mode, latched at start.
- cfg_num_rows  in  ROW_W  rows in the tile, latched at start.
- cfg_num_cols  in  $clog2(NUM_COLS+1)  columns per row, 0..NUM_COLS, latched at start.
- scale_wr_en  in  1  scale table write strobe.
- scale_wr_addr  in  $clog2(NUM_COLS)  table index.
- scale_wr_data  in  32  FP32 scale bits.
- psum_in_valid  in  1  input element valid.
- psum_in  in  PSUM_WIDTH  input element.
- psum_in_ready  out  1  input accept.
- dq_in_valid  out  1  to dequanter dequant_in_valid.
- dq_in  out  PSUM_WIDTH  to dequanter dequant_in.
- dq_scale  out  32  to dequanter scale_fp32_in.
- dq_enable  out  1  to dequanter dequant_enable.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at job end.
- cfg_err  out  1  sticky illegal-access flag.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-low.
- Reset values (rst low at a clk edge):
  - state=IDLE.
  - All outputs 0.
  - Counters 0.
  - All scale table entries = 32'h3F800000 (1.0).
  - Reset mid-job aborts with no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - Scale writes accepted; out-of-range address (>=NUM_COLS) is ignored and sets cfg_err.
  - cfg_start latches the job config.
  - If num_rows==0 or num_cols==0 (or num_cols>NUM_COLS, which also sets cfg_err), go to DONE; otherwise go to RUN.
  - A write and a start in the same cycle: the write lands first and is visible to the job.
- RUN:
  - psum_in_ready=1.
  - Accept when psum_in_valid && psum_in_ready.
  - On accept: output register loads dq_in=psum_in, dq_scale=table[col], dq_enable=latched en, dq_in_valid=1 next cycle. Latency is exactly 1 cycle.
  - Without an accept, dq_in_valid=0 next cycle.
  - col increments and wraps num_cols-1→0; row increments on wrap.
  - Accept of the last element (row=num_rows-1, col=num_cols-1): go to DRAIN and drop ready in the same edge.
- DRAIN: one cycle, last dq_in_valid visible; then DONE.
- DONE: done=1 for one cycle, counters cleared, then IDLE.
- Illegal accesses while busy:
  - cfg_start ignored, cfg_err set.
  - scale_wr_en ignored, cfg_err set.
- cfg_err clears only on reset.
- dq_in, dq_scale, dq_enable hold their last values when dq_in_valid=0.
- Counter widths: row has ROW_W bits; col is sized for NUM_COLS; no overflow is possible given the latched bounds.

Optional Feature:
- Macro: VPE_DEQUANT_SCHED_BACKPRESSURE_EN.
- With the macro defined:
  - Adds port dq_in_ready (in, 1).
  - The output register holds while dq_in_valid && !dq_in_ready.
  - psum_in_ready = RUN && (!dq_in_valid || dq_in_ready).
  - DRAIN persists until the final element is taken (dq_in_valid && dq_in_ready).
- Without the macro: the downstream is always ready, and the behaviour is as above.

Decomposition:
- Package vpe_pkg:
  - sched_state_t enum {IDLE, RUN, DRAIN, DONE}.
  - FP32_ONE = 32'h3F800000.
- Sub-module vpe_scale_table:
  - NUM_COLS x 32 register file.
  - Synchronous write, combinational read, reset to FP32_ONE.

Test Plan:
1. Reset, then a 2x3 job, en=1, scales {0.5,1.0,2.0} written to addresses 0..2, PSUMs 10..15 streamed back-to-back → dq_in_valid high 6 cycles, each one cycle after its accept; dq_scale sequence 3F000000, 3F800000, 40000000, repeated; done pulses once, 2 cycles after the last accept.
2. Job with en=0, num_rows=1, num_cols=NUM_COLS, gaps in psum_in_valid → dq_enable=0 throughout, dq_in_valid only after accepts, columns still map to addresses 0..7.
3. num_rows=0 start → RUN skipped; done pulses 1 cycle after start; psum_in_ready never high.
4. cfg_start and scale_wr_en issued during RUN → both ignored, cfg_err=1, job output unchanged; scale_wr_addr=NUM_COLS in IDLE → cfg_err=1, table unchanged.
5. rst low mid-row → next cycle busy=0, dq_in_valid=0, no done; a new job reads scales of 1.0.
6. (macro) dq_in_ready held low 3 cycles mid-stream → dq_in stable, psum_in_ready=0, no element lost or duplicated across the 6 outputs.

Source files
------------

// File: rtl/vpe_pkg.sv
// Shared types and constants for the vpe dequant scheduler slice.
package vpe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

  localparam logic [31:0] FP32_ONE = 32'h3F80_0000;

endpackage

// File: rtl/vpe_scale_table.sv
// Per-column FP32 scale register file: synchronous write, combinational read,
// every entry returns to 1.0 on reset.
module vpe_scale_table
  import vpe_pkg::*;
#(
  parameter int NUM_COLS = 8,
  parameter int AW       = $clog2(NUM_COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] entries [NUM_COLS];

  // The caller only raises wr_en for in-range addresses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        entries[i] <= FP32_ONE;
      end
    end else if (wr_en) begin
      entries[wr_addr] <= wr_data;
    end
  end

  assign rd_data = entries[rd_addr];

endmodule

// File: rtl/vpe_dequant_sched.sv
// Per-tile sequencer feeding the vpe_dequanter: tags a row-major PSUM stream
// with per-column scales. Optional downstream backpressure via macro
// VPE_DEQUANT_SCHED_BACKPRESSURE_EN.
module vpe_dequant_sched
  import vpe_pkg::*;
#(
  parameter int PSUM_WIDTH = 32,
  parameter int NUM_COLS   = 8,
  parameter int ROW_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_start,
  input  logic                            cfg_dequant_en,
  input  logic [ROW_W-1:0]                cfg_num_rows,
  input  logic [$clog2(NUM_COLS+1)-1:0]   cfg_num_cols,
  input  logic                            scale_wr_en,
  input  logic [$clog2(NUM_COLS)-1:0]     scale_wr_addr,
  input  logic [31:0]                     scale_wr_data,
  input  logic                            psum_in_valid,
  input  logic [PSUM_WIDTH-1:0]           psum_in,
  output logic                            psum_in_ready,
  output logic                            dq_in_valid,
  output logic [PSUM_WIDTH-1:0]           dq_in,
  output logic [31:0]                     dq_scale,
  output logic                            dq_enable,
`ifdef VPE_DEQUANT_SCHED_BACKPRESSURE_EN
  input  logic                            dq_in_ready,
`endif
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err
);

  localparam int AW = $clog2(NUM_COLS);
  localparam int CW = $clog2(NUM_COLS + 1);

  sched_state_t state, next_state;

  logic             job_en;
  logic [ROW_W-1:0] num_rows_q;
  logic [CW-1:0]    num_cols_q;
  logic [ROW_W-1:0] row_cnt;
  logic [AW-1:0]    col_cnt;

  logic        idle;
  logic        ds_ready;
  logic        accept;
  logic        col_wrap;
  logic        row_last;
  logic        last_elem;
  logic        drain_exit;
  logic        wr_addr_oob;
  logic        cols_oob;
  logic        cfg_bad;
  logic        table_wr_en;
  logic [31:0] col_scale;

`ifdef VPE_DEQUANT_SCHED_BACKPRESSURE_EN
  assign ds_ready = dq_in_ready;
`else
  assign ds_ready = 1'b1;
`endif

  assign idle = (state == IDLE);

  // Range checks widen to 32 bits so they stay meaningful for any NUM_COLS.
  assign wr_addr_oob = 32'(scale_wr_addr) >= 32'(NUM_COLS);
  assign cols_oob    = 32'(cfg_num_cols) > 32'(NUM_COLS);
  assign cfg_bad     = (cfg_num_rows == '0) || (cfg_num_cols == '0) || cols_oob;
  assign table_wr_en = scale_wr_en && idle && !wr_addr_oob;

  assign psum_in_ready = (state == RUN) && (!dq_in_valid || ds_ready);
  assign accept        = psum_in_valid && psum_in_ready;

  assign col_wrap   = (CW'(col_cnt) + CW'(1)) == num_cols_q;
  assign row_last   = (row_cnt + ROW_W'(1)) == num_rows_q;
  assign last_elem  = col_wrap && row_last;
  assign drain_exit = dq_in_valid && ds_ready;

  assign busy = !idle;
  assign done = (state == DONE);

  vpe_scale_table #(
    .NUM_COLS (NUM_COLS),
    .AW       (AW)
  ) u_scale_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (table_wr_en),
    .wr_addr (scale_wr_addr),
    .wr_data (scale_wr_data),
    .rd_addr (col_cnt),
    .rd_data (col_scale)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Degenerate tiles skip RUN and still produce a done pulse.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cfg_start) next_state = cfg_bad ? DONE : RUN;
      RUN:     if (accept && last_elem) next_state = DRAIN;
      DRAIN:   if (drain_exit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      job_en      <= 1'b0;
      num_rows_q  <= '0;
      num_cols_q  <= '0;
      row_cnt     <= '0;
      col_cnt     <= '0;
      cfg_err     <= 1'b0;
      dq_in_valid <= 1'b0;
      dq_in       <= '0;
      dq_scale    <= '0;
      dq_enable   <= 1'b0;
    end else begin
      if (!idle && (cfg_start || scale_wr_en)) begin
        cfg_err <= 1'b1;
      end
      if (idle && scale_wr_en && wr_addr_oob) begin
        cfg_err <= 1'b1;
      end

      if (idle && cfg_start) begin
        job_en     <= cfg_dequant_en;
        num_rows_q <= cfg_num_rows;
        num_cols_q <= cfg_num_cols;
        row_cnt    <= '0;
        col_cnt    <= '0;
        if (cols_oob) begin
          cfg_err <= 1'b1;
        end
      end

      if (accept) begin
        if (col_wrap) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + ROW_W'(1);
        end else begin
          col_cnt <= col_cnt + AW'(1);
        end
      end

      if (state == DONE) begin
        row_cnt <= '0;
        col_cnt <= '0;
      end

      // The output slot is free whenever accept is possible, so a load never
      // overwrites an element the dequanter has not taken.
      if (accept) begin
        dq_in_valid <= 1'b1;
        dq_in       <= psum_in;
        dq_scale    <= col_scale;
        dq_enable   <= job_en;
      end else if (ds_ready) begin
        dq_in_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vpe_dequant_sched.sv
// Scoreboard bench for vpe_dequant_sched; covers the backpressure build when
// VPE_DEQUANT_SCHED_BACKPRESSURE_EN is defined.
module tb_vpe_dequant_sched;
  import vpe_pkg::*;

  localparam int PW = 32;
  localparam int NC = 6;
  localparam int RW = 16;
  localparam int AW = $clog2(NC);
  localparam int CW = $clog2(NC + 1);

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] scale;
    logic        en;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          cfg_start;
  logic          cfg_dequant_en;
  logic [RW-1:0] cfg_num_rows;
  logic [CW-1:0] cfg_num_cols;
  logic          scale_wr_en;
  logic [AW-1:0] scale_wr_addr;
  logic [31:0]   scale_wr_data;
  logic          psum_in_valid;
  logic [PW-1:0] psum_in;
  logic          psum_in_ready;
  logic          dq_in_valid;
  logic [PW-1:0] dq_in;
  logic [31:0]   dq_scale;
  logic          dq_enable;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic          bp_rdy;

  exp_t        q[$];
  exp_t        last_out;
  logic [31:0] mscale [NC];
  bit          run_on, in_drain, exp_valid, exp_done, start_good, start_short;
  bit          men;
  int          mrow, mcol, mrows, mcols;
  int          job_acc, n_out;
  int          n_checks, n_fail;

  vpe_dequant_sched #(
    .PSUM_WIDTH (PW),
    .NUM_COLS   (NC),
    .ROW_W      (RW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_dequant_en (cfg_dequant_en),
    .cfg_num_rows   (cfg_num_rows),
    .cfg_num_cols   (cfg_num_cols),
    .scale_wr_en    (scale_wr_en),
    .scale_wr_addr  (scale_wr_addr),
    .scale_wr_data  (scale_wr_data),
    .psum_in_valid  (psum_in_valid),
    .psum_in        (psum_in),
    .psum_in_ready  (psum_in_ready),
    .dq_in_valid    (dq_in_valid),
    .dq_in          (dq_in),
    .dq_scale       (dq_scale),
    .dq_enable      (dq_enable),
`ifdef VPE_DEQUANT_SCHED_BACKPRESSURE_EN
    .dq_in_ready    (bp_rdy),
`endif
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check1("dq_in_valid", dq_in_valid, exp_valid);
    check1("done", done, exp_done);
    check1("busy", busy, run_on || in_drain || exp_done);
    if (exp_valid) begin
      if (q.size() > 0) begin
        check("dq_in", dq_in, q[0].data);
        check("dq_scale", dq_scale, q[0].scale);
        check1("dq_enable", dq_enable, q[0].en);
      end
    end else begin
      check("dq_in_hold", dq_in, last_out.data);
      check("dq_scale_hold", dq_scale, last_out.scale);
    end
  endtask

  // One clock of stimulus: inputs are already driven; update the model for
  // this edge, then check outputs at the following falling edge.
  task automatic clock_cycle();
    logic exp_ready, acc, taken, lastel, nd;
    #1;
    exp_ready = run_on && (!exp_valid || bp_rdy);
    check1("psum_in_ready", psum_in_ready, exp_ready);
    acc    = psum_in_valid && exp_ready;
    taken  = exp_valid && bp_rdy;
    lastel = (mrow == mrows - 1) && (mcol == mcols - 1);
    if (taken) begin
      if (dq_in_valid) n_out++;
      if (q.size() > 0) last_out = q.pop_front();
    end
    if (acc) begin
      q.push_back('{data: psum_in, scale: mscale[mcol], en: men});
      job_acc++;
      if (mcol == mcols - 1) begin
        mcol = 0;
        mrow++;
      end else begin
        mcol++;
      end
    end
    nd         = (in_drain && taken) || start_short;
    in_drain   = (acc && lastel) || (in_drain && !taken);
    run_on     = (run_on && !(acc && lastel)) || start_good;
    exp_valid  = acc || (exp_valid && !bp_rdy);
    exp_done   = nd;
    start_good  = 1'b0;
    start_short = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    cfg_start     = 1'b0;
    scale_wr_en   = 1'b0;
    psum_in_valid = 1'b0;
    bp_rdy        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    last_out    = '0;
    run_on      = 1'b0;
    in_drain    = 1'b0;
    exp_valid   = 1'b0;
    exp_done    = 1'b0;
    start_good  = 1'b0;
    start_short = 1'b0;
    for (int i = 0; i < NC; i++) mscale[i] = FP32_ONE;
    check1("rst_dq_in_valid", dq_in_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_cfg_err", cfg_err, 1'b0);
    check1("rst_psum_in_ready", psum_in_ready, 1'b0);
    check("rst_dq_in", dq_in, 32'h0);
    check("rst_dq_scale", dq_scale, 32'h0);
    check1("rst_dq_enable", dq_enable, 1'b0);
  endtask

  task automatic write_scale(input logic [AW-1:0] addr, input logic [31:0] data);
    scale_wr_en   = 1'b1;
    scale_wr_addr = addr;
    scale_wr_data = data;
    if (int'(addr) < NC) mscale[addr] = data;
    clock_cycle();
    scale_wr_en = 1'b0;
  endtask

  task automatic start_job(input logic en, input logic [RW-1:0] rows, input logic [CW-1:0] cols);
    cfg_dequant_en = en;
    cfg_num_rows   = rows;
    cfg_num_cols   = cols;
    cfg_start      = 1'b1;
    men   = en;
    mrows = int'(rows);
    mcols = int'(cols);
    mrow  = 0;
    mcol  = 0;
    job_acc = 0;
    n_out   = 0;
    if (rows == '0 || cols == '0 || int'(cols) > NC) start_short = 1'b1;
    else start_good = 1'b1;
    clock_cycle();
    cfg_start = 1'b0;
  endtask

  // Streams a job's elements; psum_in only advances once the model accepts.
  task automatic applyStimulus(input int total, input bit gappy, input int stall_at,
                               input logic [31:0] base);
    int guard;
    guard = 0;
    while (job_acc < total && guard < 200) begin
      psum_in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      psum_in       = base + 32'(job_acc);
      bp_rdy        = !(stall_at >= 0 && guard >= stall_at && guard < stall_at + 3);
      clock_cycle();
      guard++;
    end
    psum_in_valid = 1'b0;
    bp_rdy        = 1'b1;
    repeat (4) clock_cycle();
    check("out_count", 32'(n_out), 32'(total));
  endtask

  initial begin
    rst = 1'b0; cfg_start = 1'b0; cfg_dequant_en = 1'b0;
    cfg_num_rows = '0; cfg_num_cols = '0;
    scale_wr_en = 1'b0; scale_wr_addr = '0; scale_wr_data = '0;
    psum_in_valid = 1'b0; psum_in = '0; bp_rdy = 1'b1;
    n_checks = 0; n_fail = 0; job_acc = 0; n_out = 0;
    mrow = 0; mcol = 0; mrows = 0; mcols = 0; men = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    $display("[TB] 2x3 job, en=1, back-to-back");
    write_scale(3'd0, 32'h3F00_0000);
    write_scale(3'd1, 32'h3F80_0000);
    scale_wr_en = 1'b1; scale_wr_addr = 3'd2; scale_wr_data = 32'h4000_0000;
    mscale[2] = 32'h4000_0000;
    start_job(1'b1, 16'd2, 3'd3);
    scale_wr_en = 1'b0;
    applyStimulus(6, 1'b0, -1, 32'd10);
    check1("t1_cfg_err", cfg_err, 1'b0);

    $display("[TB] degenerate jobs");
    start_job(1'b1, 16'd0, 3'd3);
    repeat (2) clock_cycle();
    start_job(1'b0, 16'd2, 3'd0);
    repeat (2) clock_cycle();
    check1("t3_cfg_err", cfg_err, 1'b0);

    $display("[TB] out-of-range scale address");
    write_scale(3'd6, 32'h1234_5678);
    check1("oob_addr_cfg_err", cfg_err, 1'b1);

    $display("[TB] 1xNUM_COLS job, en=0, gappy input");
    for (int i = 0; i < NC; i++) write_scale(AW'(i), 32'h4100_0000 + 32'(i));
    start_job(1'b0, 16'd1, 3'(NC));
    applyStimulus(NC, 1'b1, -1, 32'h300);

    $display("[TB] num_cols above NUM_COLS");
    do_reset();
    start_job(1'b1, 16'd1, 3'd7);
    repeat (2) clock_cycle();
    check1("oob_cols_cfg_err", cfg_err, 1'b1);

    $display("[TB] illegal start and write during RUN");
    do_reset();
    write_scale(3'd2, 32'h4040_0000);
    start_job(1'b1, 16'd1, 3'd4);
    for (int k = 0; k < 4; k++) begin
      psum_in_valid = 1'b1;
      psum_in       = 32'h200 + 32'(k);
      if (k == 1) begin
        cfg_start = 1'b1; cfg_num_rows = 16'd5; cfg_num_cols = 3'd2;
        scale_wr_en = 1'b1; scale_wr_addr = 3'd2; scale_wr_data = 32'hDEAD_BEEF;
      end
      clock_cycle();
      cfg_start = 1'b0;
      scale_wr_en = 1'b0;
    end
    psum_in_valid = 1'b0;
    repeat (4) clock_cycle();
    check("t4_out_count", 32'(n_out), 32'd4);
    check1("t4_cfg_err", cfg_err, 1'b1);

    $display("[TB] reset mid-row");
    do_reset();
    write_scale(3'd0, 32'h4080_0000);
    write_scale(3'd1, 32'h40A0_0000);
    start_job(1'b1, 16'd2, 3'd4);
    for (int k = 0; k < 3; k++) begin
      psum_in_valid = 1'b1;
      psum_in       = 32'h400 + 32'(k);
      clock_cycle();
    end
    do_reset();
    repeat (3) clock_cycle();
    start_job(1'b1, 16'd1, 3'd3);
    applyStimulus(3, 1'b0, -1, 32'h500);

`ifdef VPE_DEQUANT_SCHED_BACKPRESSURE_EN
    $display("[TB] downstream stall mid-stream");
    write_scale(3'd1, 32'h3E80_0000);
    start_job(1'b1, 16'd2, 3'd3);
    applyStimulus(6, 1'b0, 2, 32'h600);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
